// File: rtl/alu_pkg.sv
// Shared opcode encoding and datapath widths for the ALU command issuer
// and anything that talks to the registered 8-bit ALU.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_LSL = 2'b10;
  localparam logic [OP_W-1:0] OP_LSR = 2'b11;

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured ALU results.
// Read data is forced to zero while empty so idle outputs are clean.
module alu_res_fifo #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oPopData,
  output logic             oFull,
  output logic             oEmpty,
  output logic [AW:0]      oCount
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign oCount   = wrPtr - rdPtr;
  assign oFull    = (oCount == (AW+1)'(DEPTH));
  assign oEmpty   = (oCount == '0);
  assign doPop    = iPop && !oEmpty;
  assign doPush   = iPush && (!oFull || doPop);
  assign oPopData = oEmpty ? '0 : mem[rdPtr[AW-1:0]];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= iPushData;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues valid/ready commands to the one-cycle registered ALU and returns the
// results in order, tagged, with credit-based flow control so none are dropped.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [OP_W-1:0]   iCMD_OP,
  input  logic [DATA_W-1:0] iCMD_A,
  input  logic [DATA_W-1:0] iCMD_B,
  output logic [OP_W-1:0]   oALU_OPCODE,
  output logic [DATA_W-1:0] oALU_DATAIN1,
  output logic [DATA_W-1:0] oALU_DATAIN2,
  input  logic [DATA_W-1:0] iALU_DATAOUT,
  output logic              oRES_VALID,
  input  logic              iRES_READY,
  output logic [DATA_W-1:0] oRES_DATA,
  output logic [OP_W-1:0]   oRES_OP,
  output logic [TAG_W-1:0]  oRES_TAG,
  output logic              oBUSY
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
  } resEntry_t;

  logic             s1Valid;
  logic             s2Valid;
  logic [OP_W-1:0]  s1Op;
  logic [OP_W-1:0]  s2Op;
  logic [TAG_W-1:0] s1Tag;
  logic [TAG_W-1:0] s2Tag;
  logic [TAG_W-1:0] tagCnt;
  logic             cmdAccept;
  logic             resPop;
  logic [OCC_W-1:0] occupancy;
  logic [AW:0]      fifoCount;
  logic             fifoFull;
  logic             fifoEmpty;
  resEntry_t        pushEntry;
  resEntry_t        popEntry;

  // Every accepted command holds one credit until its result is popped.
  assign occupancy = OCC_W'(s1Valid) + OCC_W'(s2Valid) + OCC_W'(fifoCount);
  assign oCMD_READY = !iRST && (occupancy < OCC_W'(DEPTH));
  assign oBUSY      = (occupancy != '0);
  assign cmdAccept  = iCMD_VALID && oCMD_READY;
  assign resPop     = oRES_VALID && iRES_READY;

  always_ff @(posedge iCLK) begin
    // NOTE: all state updates are non-blocking so every register samples the
    // pre-edge value of its neighbours, which is what makes s1 -> s2 a pipeline.
    if (iRST) begin
      oALU_OPCODE  <= '0;
      oALU_DATAIN1 <= '0;
      oALU_DATAIN2 <= '0;
      s1Valid      <= 1'b0;
      s2Valid      <= 1'b0;
      s1Op         <= '0;
      s2Op         <= '0;
      s1Tag        <= '0;
      s2Tag        <= '0;
      tagCnt       <= '0;
    end else begin
      if (cmdAccept) begin
        oALU_OPCODE  <= iCMD_OP;
        oALU_DATAIN1 <= iCMD_A;
        oALU_DATAIN2 <= iCMD_B;
        s1Op         <= iCMD_OP;
        s1Tag        <= tagCnt;
        tagCnt       <= tagCnt + TAG_W'(1);
      end
      s1Valid <= cmdAccept;
      s2Valid <= s1Valid;
      s2Op    <= s1Op;
      s2Tag   <= s1Tag;
    end
  end

  // s2 lines up with the cycle in which the ALU presents this command's result.
  assign pushEntry = '{data: iALU_DATAOUT, op: s2Op, tag: s2Tag};

  alu_res_fifo #(
    .WIDTH ($bits(resEntry_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iPush     (s2Valid),
    .iPushData (pushEntry),
    .iPop      (resPop),
    .oPopData  (popEntry),
    .oFull     (fifoFull),
    .oEmpty    (fifoEmpty),
    .oCount    (fifoCount)
  );

  assign oRES_VALID = !fifoEmpty;
  assign oRES_DATA  = popEntry.data;
  assign oRES_OP    = popEntry.op;
  assign oRES_TAG   = popEntry.tag;

  // Credits make a push into a full FIFO without a matching pop impossible.
  assert property (@(posedge iCLK) disable iff (iRST) !(s2Valid && fifoFull && !resPop));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a registered ALU model attached.
// Expected results come from plain modular arithmetic on the accepted commands.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic             iCMD_VALID = 1'b0;
  logic             oCMD_READY;
  logic [1:0]       iCMD_OP = '0;
  logic [7:0]       iCMD_A = '0;
  logic [7:0]       iCMD_B = '0;
  logic [1:0]       oALU_OPCODE;
  logic [7:0]       oALU_DATAIN1;
  logic [7:0]       oALU_DATAIN2;
  logic [7:0]       iALU_DATAOUT;
  logic             oRES_VALID;
  logic             iRES_READY = 1'b0;
  logic [7:0]       oRES_DATA;
  logic [1:0]       oRES_OP;
  logic [TAG_W-1:0] oRES_TAG;
  logic             oBUSY;

  always #5 iCLK = ~iCLK;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iCMD_VALID   (iCMD_VALID),
    .oCMD_READY   (oCMD_READY),
    .iCMD_OP      (iCMD_OP),
    .iCMD_A       (iCMD_A),
    .iCMD_B       (iCMD_B),
    .oALU_OPCODE  (oALU_OPCODE),
    .oALU_DATAIN1 (oALU_DATAIN1),
    .oALU_DATAIN2 (oALU_DATAIN2),
    .iALU_DATAOUT (iALU_DATAOUT),
    .oRES_VALID   (oRES_VALID),
    .iRES_READY   (iRES_READY),
    .oRES_DATA    (oRES_DATA),
    .oRES_OP      (oRES_OP),
    .oRES_TAG     (oRES_TAG),
    .oBUSY        (oBUSY)
  );

  // The registered ALU the issuer drives: one-cycle latency, no enable.
  always_ff @(posedge iCLK) begin
    case (oALU_OPCODE)
      OP_ADD:  iALU_DATAOUT <= oALU_DATAIN1 + oALU_DATAIN2;
      OP_SUB:  iALU_DATAOUT <= oALU_DATAIN1 - oALU_DATAIN2;
      OP_LSL:  iALU_DATAOUT <= oALU_DATAIN1 << 1;
      default: iALU_DATAOUT <= oALU_DATAIN1 >> 1;
    endcase
  end

  typedef struct {
    int data;
    int op;
    int tag;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int   nChecks = 0;
  int   nErrors = 0;
  int   expTag  = 0;
  int   nAcc    = 0;
  int   nPop    = 0;
  bit   havePending = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return (a * 2) % 256;
      default: return a / 2;
    endcase
  endfunction

  function automatic exp_t expect_for(input int op, input int a, input int b, input int tag);
    exp_t r;
    r.data = model(op, a, b);
    r.op   = op;
    r.tag  = tag;
    return r;
  endfunction

  // Monitor: occupancy model is simply accepted minus consumed.
  always @(negedge iCLK) begin
    if (iRST) begin
      nAcc = 0;
      nPop = 0;
    end else begin
      check("cmd_ready", int'(oCMD_READY), int'((nAcc - nPop) < DEPTH));
      check("busy", int'(oBUSY), int'((nAcc - nPop) != 0));
      if (iCMD_VALID && oCMD_READY) nAcc++;
      if (oRES_VALID && iRES_READY) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("FAIL res_unexpected: got data 0x%0h tag %0d with nothing expected", oRES_DATA, oRES_TAG);
        end else begin
          e = expQ.pop_front();
          check("res_data", int'(oRES_DATA), e.data);
          check("res_op", int'(oRES_OP), e.op);
          check("res_tag", int'(oRES_TAG), e.tag);
        end
        nPop++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic record_accept();
    expQ.push_back(expect_for(int'(iCMD_OP), int'(iCMD_A), int'(iCMD_B), expTag));
    expTag = (expTag + 1) % (1 << TAG_W);
  endtask

  // Presents one command and holds it until accepted; VALID stays high afterwards.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    iCMD_OP    = op;
    iCMD_A     = a;
    iCMD_B     = b;
    iCMD_VALID = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge iCLK);
      if (oCMD_READY) begin
        record_accept();
        @(posedge iCLK);
        #1;
        return;
      end
      @(posedge iCLK);
      #1;
    end
    nChecks++;
    nErrors++;
    $display("FAIL cmd_timeout: command op %0d never accepted", op);
  endtask

  // Streams up to n commands within maxCycles; an unaccepted command stays presented.
  task automatic burst(input int n, input int maxCycles, input int opSel, input bit randReady,
                       output int sent);
    sent = 0;
    for (int cyc = 0; cyc < maxCycles && sent < n; cyc++) begin
      if (!havePending) begin
        iCMD_OP     = (opSel < 0) ? 2'($urandom_range(0, 3)) : 2'(opSel);
        iCMD_A      = 8'($urandom);
        iCMD_B      = 8'($urandom);
        havePending = 1'b1;
      end
      iCMD_VALID = 1'b1;
      if (randReady) iRES_READY = ($urandom_range(0, 3) != 0);
      @(negedge iCLK);
      if (oCMD_READY) begin
        record_accept();
        sent++;
        havePending = 1'b0;
      end
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tagName);
    check({tagName, "_alu_op"}, int'(oALU_OPCODE), 0);
    check({tagName, "_alu_in1"}, int'(oALU_DATAIN1), 0);
    check({tagName, "_alu_in2"}, int'(oALU_DATAIN2), 0);
    check({tagName, "_res_valid"}, int'(oRES_VALID), 0);
    check({tagName, "_res_data"}, int'(oRES_DATA), 0);
    check({tagName, "_res_op"}, int'(oRES_OP), 0);
    check({tagName, "_res_tag"}, int'(oRES_TAG), 0);
    check({tagName, "_busy"}, int'(oBUSY), 0);
    check({tagName, "_cmd_ready"}, int'(oCMD_READY), 0);
  endtask

  task automatic pulse_reset(input string tagName);
    iRST       = 1'b1;
    iCMD_VALID = 1'b0;
    expQ.delete();
    expTag      = 0;
    havePending = 1'b0;
    tick(1);
    check_reset_outputs(tagName);
    iRST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int sent2;

    tick(2);
    check_reset_outputs("init");
    iRST = 1'b0;
    @(negedge iCLK);
    check("ready_after_release", int'(oCMD_READY), 1);
    tick(1);

    // First-result latency with an empty FIFO.
    iRES_READY = 1'b1;
    issue(OP_ADD, 8'h7F, 8'h01);
    iCMD_VALID = 1'b0;
    @(negedge iCLK);
    check("lat_after_e0", int'(oRES_VALID), 0);
    tick(1);
    @(negedge iCLK);
    check("lat_after_e1", int'(oRES_VALID), 0);
    tick(1);
    @(negedge iCLK);
    check("lat_after_e2", int'(oRES_VALID), 1);
    tick(2);

    // Back-to-back mixed ops.
    issue(OP_SUB, 8'h00, 8'h01);
    issue(OP_LSL, 8'h81, 8'h00);
    issue(OP_LSR, 8'h81, 8'h00);
    iCMD_VALID = 1'b0;
    tick(6);

    // Backpressure: exactly DEPTH accepted, then the rest after release.
    iRES_READY = 1'b0;
    burst(6, 12, -1, 1'b0, sent);
    check("bp_accepted", sent, DEPTH);
    check("bp_ready_low", int'(oCMD_READY), 0);
    iRES_READY = 1'b1;
    burst(6 - sent, 20, -1, 1'b0, sent2);
    check("bp_rest_accepted", sent2, 6 - sent);
    iCMD_VALID = 1'b0;
    tick(8);

    // Full FIFO, then pops overlapping with fresh accepts.
    iRES_READY = 1'b0;
    burst(DEPTH, 10, -1, 1'b0, sent);
    check("full_fill", sent, DEPTH);
    tick(3);
    iRES_READY = 1'b1;
    burst(8, 30, -1, 1'b0, sent);
    check("full_overlap", sent, 8);
    iCMD_VALID = 1'b0;
    tick(8);

    // Reset with results in flight and queued.
    iRES_READY = 1'b0;
    issue(OP_ADD, 8'h10, 8'h01);
    issue(OP_ADD, 8'h20, 8'h02);
    issue(OP_ADD, 8'h30, 8'h03);
    pulse_reset("mid_rst");
    iRES_READY = 1'b1;
    tick(4);
    check("post_rst_idle", int'(oRES_VALID), 0);
    issue(OP_ADD, 8'h05, 8'h06);
    iCMD_VALID = 1'b0;
    tick(6);

    // Tag wrap across 17 consecutive ADDs.
    pulse_reset("wrap_rst");
    burst(17, 40, 0, 1'b0, sent);
    check("wrap_sent", sent, 17);
    iCMD_VALID = 1'b0;
    tick(6);

    // Randomized traffic with random consumer backpressure.
    burst(150, 800, -1, 1'b1, sent);
    check("rand_sent", sent, 150);
    iCMD_VALID  = 1'b0;
    havePending = 1'b0;
    iRES_READY  = 1'b1;
    for (int c = 0; c < 50 && expQ.size() != 0; c++) tick(1);
    check("drain_empty", expQ.size(), 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
